// File: rtl/led_panel_pkg.sv
// Shared definitions for the 64x64 LED panel framebuffer: geometry, word layout and writer states.
package led_panel_pkg;

    localparam int ROW_W     = 5;
    localparam int COL_W     = 6;
    localparam int RGB_W     = 3;
    localparam int ADDR_W    = ROW_W + COL_W;
    localparam int WORD_W    = 2 * RGB_W;
    localparam int NUM_WORDS = 2048;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        MERGE,
        CLR
    } state_t;

    // Replace one half-panel pixel in a word, keeping the pixel of the other half.
    function automatic logic [WORD_W-1:0] merge_pixel(
        input logic [WORD_W-1:0] word,
        input logic              bottom,
        input logic [RGB_W-1:0]  rgb
    );
        if (bottom)
            return {word[WORD_W-1:RGB_W], rgb};
        else
            return {rgb, word[RGB_W-1:0]};
    endfunction

endpackage

// File: rtl/count.sv
// Free-running up counter with synchronous reset, synchronous clear-to-zero and increment enable.
module count #(
    parameter int width = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             zero,
    input  logic             inc,
    output logic [width-1:0] outc
);

    always_ff @(posedge clk) begin
        if (reset || zero)
            outc <= '0;
        else if (inc)
            outc <= outc + 1'b1;
    end

endmodule

// File: rtl/led_fb_writer.sv
// Write-side agent of the LED panel framebuffer: read-modify-write pixel updates and full-frame clears.
module led_fb_writer
    import led_panel_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [COL_W-1:0]  pix_x,
    input  logic [ROW_W:0]    pix_y,
    input  logic [RGB_W-1:0]  pix_rgb,
    input  logic              clr,
    input  logic [RGB_W-1:0]  clr_rgb,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              mem_wr,
    output logic [WORD_W-1:0] mem_wdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(NUM_WORDS - 2);

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                half_q;
    logic [RGB_W-1:0]    rgb_q;
    logic [ADDR_W-1:0]   sweep;
    logic                clr_start;
    logic                pix_accept;

    assign clr_start  = (state == IDLE) && clr;
    assign pix_accept = (state == IDLE) && !clr && pix_valid;
    assign pix_ready  = (state == IDLE) && !clr;
    assign busy       = (state != IDLE);

    count #(.width(ADDR_W)) u_sweep (
        .clk   (clk),
        .reset (rst),
        .zero  (clr_start),
        .inc   (state == CLR),
        .outc  (sweep)
    );

    // The sweep counter is the address during a clear; read data only arrives in MERGE, so the
    // merged word is formed there combinationally rather than registered a cycle late.
    assign mem_addr  = (state == CLR) ? sweep : addr_q;
    assign mem_wdata = (state == MERGE) ? merge_pixel(mem_rdata, half_q, rgb_q) : wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            done    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            mem_rd <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr) begin
                        wdata_q <= {clr_rgb, clr_rgb};
                        mem_wr  <= 1'b1;
                        state   <= CLR;
                    end else if (pix_valid) begin
                        addr_q <= {pix_y[ROW_W-1:0], pix_x};
                        mem_rd <= 1'b1;
                        state  <= RD;
                    end
                end
                RD: begin
                    mem_wr <= 1'b1;
                    done   <= 1'b1;
                    state  <= MERGE;
                end
                MERGE: begin
                    mem_wr <= 1'b0;
                    state  <= IDLE;
                end
                CLR: begin
                    if (sweep == LAST_ADDR) begin
                        mem_wr <= 1'b0;
                        state  <= IDLE;
                    end else if (sweep == PRE_LAST) begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pix_accept) begin
            half_q <= pix_y[ROW_W];
            rgb_q  <= pix_rgb;
        end
    end

endmodule

// File: tb/tb_led_fb_writer.sv
// Directed bench for led_fb_writer with a behavioural dual-port framebuffer model.
module tb_led_fb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic        pix_ready;
    logic [5:0]  pix_x;
    logic [5:0]  pix_y;
    logic [2:0]  pix_rgb;
    logic        clr;
    logic [2:0]  clr_rgb;
    logic        busy;
    logic        done;
    logic [10:0] mem_addr;
    logic        mem_rd;
    logic [5:0]  mem_rdata;
    logic        mem_wr;
    logic [5:0]  mem_wdata;

    logic [5:0]  mem [2048];
    logic        bd_we;
    logic [10:0] bd_addr;
    logic [5:0]  bd_data;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    led_fb_writer dut (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_rgb   (pix_rgb),
        .clr       (clr),
        .clr_rgb   (clr_rgb),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata)
    );

    // Framebuffer: write on the strobe edge, read data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [10:0] a, input logic [5:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    task automatic pixel_write(input logic [5:0] x, input logic [5:0] y, input logic [2:0] rgb,
                               input logic [10:0] exp_addr, input logic [5:0] exp_wdata);
        @(negedge clk);
        pix_valid = 1'b1; pix_x = x; pix_y = y; pix_rgb = rgb;
        #1 check("pix_ready_idle", pix_ready, 1);
        @(posedge clk);
        // Scramble inputs right after acceptance: the latched request must be unaffected.
        #1 pix_valid = 1'b0; pix_x = ~x; pix_y = ~y; pix_rgb = ~rgb;
        @(negedge clk);
        check("rd_strobe", mem_rd, 1);
        check("rd_no_wr", mem_wr, 0);
        check("rd_addr", mem_addr, exp_addr);
        check("rd_busy", busy, 1);
        check("rd_ready", pix_ready, 0);
        @(negedge clk);
        check("mg_wr", mem_wr, 1);
        check("mg_no_rd", mem_rd, 0);
        check("mg_addr", mem_addr, exp_addr);
        check("mg_wdata", mem_wdata, exp_wdata);
        check("mg_done", done, 1);
        @(negedge clk);
        check("t3_done_low", done, 0);
        check("t3_wr_low", mem_wr, 0);
        check("t3_ready", pix_ready, 1);
        check("mem_word", mem[exp_addr], exp_wdata);
    endtask

    // Runs a full clear; with hold_pix the pixel request stays asserted and must be dropped.
    task automatic clear_sweep(input logic [2:0] rgb, input logic hold_pix);
        int b_wr = 0, b_addr = 0, b_data = 0, b_busy = 0, b_ready = 0, b_rd = 0, b_done = 0;
        int b_mem = 0;
        @(negedge clk);
        clr = 1'b1; clr_rgb = rgb;
        if (hold_pix) begin
            pix_valid = 1'b1; pix_x = 6'd5; pix_y = 6'd3; pix_rgb = 3'b111;
        end
        #1 check("clr_ready_low", pix_ready, 0);
        @(posedge clk);
        #1 clr = 1'b0; clr_rgb = ~rgb;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            if (mem_wr !== 1'b1) b_wr++;
            if (mem_addr !== 11'(i)) b_addr++;
            if (mem_wdata !== {rgb, rgb}) b_data++;
            if (busy !== 1'b1) b_busy++;
            if (pix_ready !== 1'b0) b_ready++;
            if (mem_rd !== 1'b0) b_rd++;
            if (done !== (i == 2047)) b_done++;
            if (i == 2047) pix_valid = 1'b0;
        end
        check("clr_wr_count_bad", b_wr, 0);
        check("clr_addr_bad", b_addr, 0);
        check("clr_wdata_bad", b_data, 0);
        check("clr_busy_bad", b_busy, 0);
        check("clr_ready_bad", b_ready, 0);
        check("clr_rd_bad", b_rd, 0);
        check("clr_done_bad", b_done, 0);
        @(negedge clk);
        check("clr_end_wr", mem_wr, 0);
        check("clr_end_busy", busy, 0);
        check("clr_end_done", done, 0);
        check("clr_end_rd", mem_rd, 0);
        for (int a = 0; a < 2048; a++)
            if (mem[a] !== {rgb, rgb}) b_mem++;
        check("clr_mem_bad", b_mem, 0);
    endtask

    initial begin
        rst = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_rgb = '0;
        clr = 1'b0; clr_rgb = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_wr", mem_wr, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_ready", pix_ready, 1);

        // Top-half pixel keeps bottom half; bottom-half pixel keeps top half
        preload(11'h0C5, 6'b010_011);
        pixel_write(6'd5, 6'd3, 3'b101, 11'h0C5, 6'b101_011);
        preload(11'h23F, 6'b111_000);
        pixel_write(6'd63, 6'd40, 3'b110, 11'h23F, 6'b111_110);

        // Plain clear, then clear with a competing pixel request
        clear_sweep(3'b001, 1'b0);
        clear_sweep(3'b010, 1'b1);

        // Reset in the middle of a clear
        @(negedge clk);
        clr = 1'b1; clr_rgb = 3'b100;
        @(posedge clk);
        #1 clr = 1'b0;
        for (int i = 0; i < 100; i++) @(posedge clk);
        @(negedge clk);
        check("mid_addr", mem_addr, 100);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wr", mem_wr, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ready", pix_ready, 1);
        check("mid_mem99", mem[99], 6'b100_100);
        check("mid_mem101", mem[101], 6'b010_010);
        repeat (3) @(negedge clk);
        check("mid_idle_wr", mem_wr, 0);
        check("mid_mem102", mem[102], 6'b010_010);
        preload(11'h0C5, 6'b010_011);
        pixel_write(6'd5, 6'd3, 3'b101, 11'h0C5, 6'b101_011);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
